// File: rtl/stream_pkg.sv
// Shared helpers for the stream join/split blocks: FIFO pointer sizing,
// depth computation and the valid/ready fire helper.
package stream_pkg;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int fifo_ptr_w(input int addr_sz);
    return addr_sz + 1;
  endfunction

  function automatic int fifo_depth(input int addr_sz);
    return 1 << addr_sz;
  endfunction

  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/stream_split_fifo.sv
// Per-side circular-buffer FIFO for stream_split. Head data reads as 0 while empty;
// full/empty/count are derived from registered pointers only.
module stream_split_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR_SZ = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_full,
  input  logic               i_rd,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_empty,
  output logic [ADDR_SZ:0]   o_count
);

  localparam int PTR_W = fifo_ptr_w(ADDR_SZ);
  localparam int DEPTH = fifo_depth(ADDR_SZ);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign count   = wr_ptr - rd_ptr;
  assign o_full  = (count == DEPTH_CNT);
  assign o_empty = (count == '0);
  assign o_count = count;

  // Overflow/underflow requests are ignored rather than corrupting the pointers.
  assign wr_en = i_wr && !o_full;
  assign rd_en = i_rd && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_SZ-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : mem[rd_ptr[ADDR_SZ-1:0]];

endmodule

// File: rtl/stream_split.sv
// Splits one valid/ready stream into independent left/right streams via per-side FIFOs.
// Optional feature macro: STREAM_SPLIT_MASK_EN adds i_mask to select written sides.
module stream_split
  import stream_pkg::*;
#(
  parameter int LEFT_WIDTH   = 8,
  parameter int RIGHT_WIDTH  = 8,
  parameter int FIFO_ADDR_SZ = 1,
  parameter int IN_WIDTH     = LEFT_WIDTH + RIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [IN_WIDTH-1:0]     i_data,
`ifdef STREAM_SPLIT_MASK_EN
  input  logic [1:0]              i_mask,
`endif
  output logic                    o_left_valid,
  input  logic                    o_left_ready,
  output logic [LEFT_WIDTH-1:0]   o_left_data,
  output logic [FIFO_ADDR_SZ:0]   o_left_count,
  output logic                    o_right_valid,
  input  logic                    o_right_ready,
  output logic [RIGHT_WIDTH-1:0]  o_right_data,
  output logic [FIFO_ADDR_SZ:0]   o_right_count
);

  // Handshake: a beat transfers on a rising clk edge where valid && ready.
  // Producers hold valid and data stable until the transfer; ready never
  // depends combinationally on the opposite side's ready.

  logic fire_in;
  logic left_full;
  logic right_full;
  logic left_empty;
  logic right_empty;
  logic left_wr;
  logic right_wr;
  logic left_rd;
  logic right_rd;

`ifdef STREAM_SPLIT_MASK_EN
  // Only sides selected by the mask can block or receive the beat.
  assign i_ready  = reset_n && !(i_mask[1] && left_full) && !(i_mask[0] && right_full);
  assign left_wr  = fire_in && i_mask[1];
  assign right_wr = fire_in && i_mask[0];
`else
  assign i_ready  = reset_n && !left_full && !right_full;
  assign left_wr  = fire_in;
  assign right_wr = fire_in;
`endif

  assign fire_in       = hs_fire(i_valid, i_ready);
  assign o_left_valid  = !left_empty;
  assign o_right_valid = !right_empty;
  assign left_rd       = hs_fire(o_left_valid, o_left_ready);
  assign right_rd      = hs_fire(o_right_valid, o_right_ready);

  stream_split_fifo #(
    .WIDTH   (LEFT_WIDTH),
    .ADDR_SZ (FIFO_ADDR_SZ)
  ) u_left_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (left_wr),
    .i_data  (i_data[IN_WIDTH-1:RIGHT_WIDTH]),
    .o_full  (left_full),
    .i_rd    (left_rd),
    .o_data  (o_left_data),
    .o_empty (left_empty),
    .o_count (o_left_count)
  );

  stream_split_fifo #(
    .WIDTH   (RIGHT_WIDTH),
    .ADDR_SZ (FIFO_ADDR_SZ)
  ) u_right_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (right_wr),
    .i_data  (i_data[RIGHT_WIDTH-1:0]),
    .o_full  (right_full),
    .i_rd    (right_rd),
    .o_data  (o_right_data),
    .o_empty (right_empty),
    .o_count (o_right_count)
  );

endmodule

// File: tb/tb_stream_split.sv
// Directed bench for stream_split: queue-based reference of both sides, a per-cycle
// compare on the falling edge, and literal expectations at key points.
module tb_stream_split;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic [1:0]  i_mask;
  logic        o_left_valid;
  logic        o_left_ready;
  logic [7:0]  o_left_data;
  logic [1:0]  o_left_count;
  logic        o_right_valid;
  logic        o_right_ready;
  logic [7:0]  o_right_data;
  logic [1:0]  o_right_count;

  logic [7:0] left_exp_q[$];
  logic [7:0] right_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  stream_split #(
    .LEFT_WIDTH   (8),
    .RIGHT_WIDTH  (8),
    .FIFO_ADDR_SZ (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .i_data        (i_data),
`ifdef STREAM_SPLIT_MASK_EN
    .i_mask        (i_mask),
`endif
    .o_left_valid  (o_left_valid),
    .o_left_ready  (o_left_ready),
    .o_left_data   (o_left_data),
    .o_left_count  (o_left_count),
    .o_right_valid (o_right_valid),
    .o_right_ready (o_right_ready),
    .o_right_data  (o_right_data),
    .o_right_count (o_right_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: which sides may take a beat, and what each side holds
  function automatic logic model_ready();
    logic lf, rf;
    lf = (left_exp_q.size() >= DEPTH);
    rf = (right_exp_q.size() >= DEPTH);
    if (!reset_n) return 1'b0;
`ifdef STREAM_SPLIT_MASK_EN
    return !(i_mask[1] && lf) && !(i_mask[0] && rf);
`else
    return !lf && !rf;
`endif
  endfunction

  always @(negedge reset_n) begin
    left_exp_q.delete();
    right_exp_q.delete();
  end

  always @(posedge clk) begin
    logic acc, push_l, push_r;
    if (!reset_n) begin
      left_exp_q.delete();
      right_exp_q.delete();
    end else begin
      acc = i_valid && model_ready();
`ifdef STREAM_SPLIT_MASK_EN
      push_l = acc && i_mask[1];
      push_r = acc && i_mask[0];
`else
      push_l = acc;
      push_r = acc;
`endif
      if (left_exp_q.size() > 0 && o_left_ready) void'(left_exp_q.pop_front());
      if (right_exp_q.size() > 0 && o_right_ready) void'(right_exp_q.pop_front());
      if (push_l) left_exp_q.push_back(i_data[15:8]);
      if (push_r) right_exp_q.push_back(i_data[7:0]);
    end
  end

  // per-cycle compare against the reference
  always @(negedge clk) begin
    chk("cyc_i_ready", 32'(i_ready), 32'(model_ready()));
    chk("cyc_l_valid", 32'(o_left_valid), 32'(left_exp_q.size() > 0));
    chk("cyc_r_valid", 32'(o_right_valid), 32'(right_exp_q.size() > 0));
    chk("cyc_l_data", 32'(o_left_data), left_exp_q.size() > 0 ? 32'(left_exp_q[0]) : 32'h0);
    chk("cyc_r_data", 32'(o_right_data), right_exp_q.size() > 0 ? 32'(right_exp_q[0]) : 32'h0);
    chk("cyc_l_count", 32'(o_left_count), 32'(left_exp_q.size()));
    chk("cyc_r_count", 32'(o_right_count), 32'(right_exp_q.size()));
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_valid       = 1'b0;
    o_left_ready  = 1'b1;
    o_right_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    i_valid       = 1'b0;
    i_data        = '0;
    i_mask        = 2'b11;
    o_left_ready  = 1'b1;
    o_right_ready = 1'b1;
    repeat (2) step();
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    chk("rst_l_count", 32'(o_left_count), 32'h0);
    chk("rst_r_valid", 32'(o_right_valid), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rel_i_ready", 32'(i_ready), 32'h1);
    step();

    // back-to-back flow
    i_valid = 1'b1; i_data = 16'h0102;
    step();
    chk("b2b_l0", 32'(o_left_data), 32'h01);
    chk("b2b_r0", 32'(o_right_data), 32'h02);
    i_data = 16'h0304;
    step();
    chk("b2b_l1", 32'(o_left_data), 32'h03);
    chk("b2b_r1", 32'(o_right_data), 32'h04);
    chk("b2b_rdy", 32'(i_ready), 32'h1);
    i_data = 16'h0506;
    step();
    chk("b2b_l2", 32'(o_left_data), 32'h05);
    chk("b2b_r2", 32'(o_right_data), 32'h06);
    i_valid = 1'b0;
    step();
    chk("b2b_empty", 32'(o_left_valid), 32'h0);

    // skewed stall: right consumer blocked
    o_right_ready = 1'b0;
    i_valid = 1'b1; i_data = 16'h1011;
    step();
    i_data = 16'h2021;
    step();
    i_data = 16'h3031;
    step();
    step();
    chk("skew_rdy_low", 32'(i_ready), 32'h0);
    chk("skew_r_count", 32'(o_right_count), 32'h2);
    chk("skew_l_count", 32'(o_left_count), 32'h0);
    o_right_ready = 1'b1;
    #1;
    chk("skew_rdy_still_low", 32'(i_ready), 32'h0);
    step();
    chk("skew_resume", 32'(i_ready), 32'h1);
    step();
    i_data = 16'h4041;
    step();
    drain();

    // output stability under left stall
    o_left_ready = 1'b0;
    i_valid = 1'b1; i_data = 16'hAA55;
    step();
    i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stable_l_data", 32'(o_left_data), 32'hAA);
      step();
    end
    o_left_ready = 1'b1;
    step();
    chk("stable_popped", 32'(o_left_valid), 32'h0);
    drain();

    // full with same-cycle pop keeps i_ready low for that cycle
    o_left_ready = 1'b0; o_right_ready = 1'b0;
    i_valid = 1'b1; i_data = 16'h1122;
    step();
    i_data = 16'h3344;
    step();
    i_data = 16'h5566;
    chk("full_count", 32'(o_left_count), 32'h2);
    o_left_ready = 1'b1; o_right_ready = 1'b1;
    #1;
    chk("full_pop_rdy", 32'(i_ready), 32'h0);
    step();
    chk("full_after_rdy", 32'(i_ready), 32'h1);
    chk("full_after_cnt", 32'(o_right_count), 32'h1);
    step();
    drain();

    // asynchronous reset mid-stream
    o_left_ready = 1'b0; o_right_ready = 1'b0;
    i_valid = 1'b1; i_data = 16'h99AB;
    step();
    i_data = 16'hCDEF;
    step();
    i_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_l_valid", 32'(o_left_valid), 32'h0);
    chk("arst_r_data", 32'(o_right_data), 32'h0);
    chk("arst_l_count", 32'(o_left_count), 32'h0);
    chk("arst_i_ready", 32'(i_ready), 32'h0);
    step();
    reset_n = 1'b1;
    o_left_ready = 1'b1; o_right_ready = 1'b1;
    i_valid = 1'b1; i_data = 16'h7788;
    step();
    chk("arst_new_l", 32'(o_left_data), 32'h77);
    chk("arst_new_r", 32'(o_right_data), 32'h88);
    drain();

`ifdef STREAM_SPLIT_MASK_EN
    // masked writes
    o_right_ready = 1'b0;
    i_mask = 2'b01; i_valid = 1'b1; i_data = 16'h0A0B;
    step();
    i_data = 16'h0C0D;
    step();
    o_left_ready = 1'b0;
    i_mask = 2'b10; i_data = 16'h0E0F;
    #1;
    chk("mask10_rdy", 32'(i_ready), 32'h1);
    step();
    chk("mask10_l_count", 32'(o_left_count), 32'h1);
    chk("mask10_r_count", 32'(o_right_count), 32'h2);
    i_mask = 2'b00; i_data = 16'h1234;
    step();
    chk("mask00_l_count", 32'(o_left_count), 32'h1);
    chk("mask00_r_count", 32'(o_right_count), 32'h2);
    i_mask = 2'b11;
    drain();
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
